ahblite_gpio_slave: RTL and testbench

AHBLITE_GPIO_SLAVE -- requirements
Module: ahblite_gpio_slave

---
 rtl/ahblite_gpio_pkg.sv | 42 ++++
 rtl/ahblite_gpio_slave_sync_edge.sv | 42 ++++
 rtl/ahblite_gpio_slave.sv | 158 +++++++++++++++
 tb/tb_ahblite_gpio_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_gpio_pkg.sv
// ahblite_gpio_pkg
// Shared constants for the AHB-Lite GPIO slave: default pin count, AHB
// transfer-type and transfer-size encodings, register byte offsets and
// the byte-lane strobe decode used by the write path.
package ahblite_gpio_pkg;

    localparam int GPIO_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic [4:0] ADDR_DOUT    = 5'h00;
    localparam logic [4:0] ADDR_DIR     = 5'h04;
    localparam logic [4:0] ADDR_DIN     = 5'h08;
    localparam logic [4:0] ADDR_INTEN   = 5'h0C;
    localparam logic [4:0] ADDR_INTPOL  = 5'h10;
    localparam logic [4:0] ADDR_INTSTAT = 5'h14;
    localparam logic [4:0] ADDR_DSET    = 5'h18;
    localparam logic [4:0] ADDR_DCLR    = 5'h1C;

    // Byte-lane strobes for a little-endian 32-bit bus. Sizes above a
    // word are not supported by this slave and are treated as a word.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: byte_strobe = 4'b0001 << addr_lo;
            HSIZE_HALF: byte_strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    byte_strobe = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahblite_gpio_slave_sync_edge.sv
// gpio_sync_edge
// Two-flop synchroniser for asynchronous pin inputs followed by a
// previous-value flop used for per-bit edge detection.
// Ports:
//   HCLK, HRESETn : clock, async active-low reset
//   pin_in        : raw asynchronous pins
//   pin_sync      : synchronised pin value (second flop)
//   rise, fall    : one-cycle pulses when pin_sync differs from its previous value
module gpio_sync_edge #(
    parameter int WIDTH = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    // All three stages reset to 0 so the first comparison after reset
    // cannot see a phantom edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pin_sync = sync2;
    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;

endmodule

// File: rtl/ahblite_gpio_slave.sv
// ahblite_gpio_slave
// Zero-wait-state AHB-Lite slave exposing a GPIO block: output data,
// direction, synchronised input, edge interrupts with per-bit polarity,
// and atomic set/clear aliases of the output register.
// Ports:
//   HCLK, HRESETn        : clock, async active-low reset
//   HSEL..HREADY         : AHB-Lite address/data phase inputs
//   HREADYOUT, HRESP     : always ready, always OKAY
//   HRDATA               : read data, combinational in the data phase
//   GPIO_IN              : asynchronous pin inputs
//   GPIO_OUT, GPIO_OE    : pin drive values and per-pin output enables
//   GPIO_IRQ             : registered level interrupt
module ahblite_gpio_slave
    import ahblite_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH = GPIO_WIDTH_DEFAULT
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic [GPIO_WIDTH-1:0] GPIO_OE,
    output logic                  GPIO_IRQ
);

    logic                  ap_valid;
    logic                  ap_write;
    logic [2:0]            ap_idx;
    logic [1:0]            ap_lo;
    logic [2:0]            ap_size;

    logic [GPIO_WIDTH-1:0] dout;
    logic [GPIO_WIDTH-1:0] dir;
    logic [GPIO_WIDTH-1:0] inten;
    logic [GPIO_WIDTH-1:0] intpol;
    logic [GPIO_WIDTH-1:0] intstat;
    logic                  gpio_irq_q;

    logic [GPIO_WIDTH-1:0] din;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;

    logic                  accept;
    logic                  wr_en;
    logic [4:0]            reg_off;
    logic [3:0]            strb;
    logic [31:0]           lane_mask;
    logic [31:0]           wbits32;
    logic [GPIO_WIDTH-1:0] wmask;
    logic [GPIO_WIDTH-1:0] wbits;
    logic [GPIO_WIDTH-1:0] w1c;
    logic [GPIO_WIDTH-1:0] edge_set;
    logic [31:0]           rdata;
    logic                  unused_bits;

    gpio_sync_edge #(.WIDTH(GPIO_WIDTH)) u_sync_edge (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .pin_in   (GPIO_IN),
        .pin_sync (din),
        .rise     (rise),
        .fall     (fall)
    );

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign wr_en   = ap_valid & ap_write;
    assign reg_off = {ap_idx, 2'b00};

    assign strb      = byte_strobe(ap_size, ap_lo);
    assign lane_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    assign wbits32   = HWDATA & lane_mask;
    assign wmask     = lane_mask[GPIO_WIDTH-1:0];
    assign wbits     = wbits32[GPIO_WIDTH-1:0];

    assign w1c      = (wr_en && reg_off == ADDR_INTSTAT) ? wbits : '0;
    assign edge_set = (rise & intpol) | (fall & ~intpol);

    // Address phase capture. A non-accepted cycle clears ap_valid so the
    // following cycle is not treated as a data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_idx   <= '0;
            ap_lo    <= '0;
            ap_size  <= '0;
        end else begin
            ap_valid <= accept;
            if (accept) begin
                ap_write <= HWRITE;
                ap_idx   <= HADDR[4:2];
                ap_lo    <= HADDR[1:0];
                ap_size  <= HSIZE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dout       <= '0;
            dir        <= '0;
            inten      <= '0;
            intpol     <= '0;
            intstat    <= '0;
            gpio_irq_q <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_off)
                    ADDR_DOUT:   dout   <= (dout & ~wmask) | wbits;
                    ADDR_DIR:    dir    <= (dir & ~wmask) | wbits;
                    ADDR_INTEN:  inten  <= (inten & ~wmask) | wbits;
                    ADDR_INTPOL: intpol <= (intpol & ~wmask) | wbits;
                    ADDR_DSET:   dout   <= dout | wbits;
                    ADDR_DCLR:   dout   <= dout & ~wbits;
                    default:     ;
                endcase
            end
            // A new edge in the same cycle as a W1C keeps the bit set.
            intstat    <= (intstat & ~w1c) | edge_set;
            gpio_irq_q <= |(intstat & inten);
        end
    end

    always_comb begin
        rdata = '0;
        if (ap_valid && !ap_write) begin
            case (reg_off)
                ADDR_DOUT:    rdata[GPIO_WIDTH-1:0] = dout;
                ADDR_DIR:     rdata[GPIO_WIDTH-1:0] = dir;
                ADDR_DIN:     rdata[GPIO_WIDTH-1:0] = din;
                ADDR_INTEN:   rdata[GPIO_WIDTH-1:0] = inten;
                ADDR_INTPOL:  rdata[GPIO_WIDTH-1:0] = intpol;
                ADDR_INTSTAT: rdata[GPIO_WIDTH-1:0] = intstat;
                default:      rdata = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign GPIO_OUT  = dout;
    assign GPIO_OE   = dir;
    assign GPIO_IRQ  = gpio_irq_q;

    assign unused_bits = ^{HADDR[31:5], HTRANS[0], wbits32, lane_mask};

endmodule

// File: tb/tb_ahblite_gpio_slave.sv
module tb_ahblite_gpio_slave;
    import ahblite_gpio_pkg::*;

    localparam int W = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [W-1:0]  GPIO_IN;
    logic [W-1:0]  GPIO_OUT;
    logic [W-1:0]  GPIO_OE;
    logic          GPIO_IRQ;

    ahblite_gpio_slave #(.GPIO_WIDTH(W)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .GPIO_IN   (GPIO_IN),
        .GPIO_OUT  (GPIO_OUT),
        .GPIO_OE   (GPIO_OE),
        .GPIO_IRQ  (GPIO_IRQ)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        hsel;
        logic [1:0]  trans;
        logic        wr;
        logic [4:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] rd_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic sel, input logic [1:0] tr, input logic wr,
                              input logic [4:0] a, input logic [2:0] sz);
        HSEL   = sel;
        HTRANS = tr;
        HWRITE = wr;
        HADDR  = 32'h4000_0000 | {27'd0, a};
        HSIZE  = sz;
    endtask

    task automatic idle();
        drive_addr(1'b0, HTRANS_IDLE, 1'b0, 5'h00, HSIZE_WORD);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [2:0] sz);
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, a, sz);
        tick();
        HWDATA = d;
        idle();
        tick();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, a, HSIZE_WORD);
        tick();
        d = HRDATA;
        idle();
    endtask

    task automatic add_vec(input logic hsel, input logic [1:0] trans, input logic wr,
                           input logic [4:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic [15:0] exp_out, input logic [15:0] exp_oe);
        vec_t v;
        v.hsel = hsel; v.trans = trans; v.wr = wr; v.addr = addr; v.size = size;
        v.wdata = wdata; v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_oe = exp_oe;
        tbl.push_back(v);
    endtask

    function automatic logic accepted(input vec_t v);
        return v.hsel & v.trans[1];
    endfunction

    initial begin
        logic [31:0] rd;
        int n;

        //       hsel trans          wr    addr   size        wdata          exp_rd         out      oe
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h04, HSIZE_WORD, 32'h0000_00FF, 32'h0,         16'h0000, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_WORD, 32'h0000_00A5, 32'h0,         16'h00A5, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h00, HSIZE_WORD, 32'h0,         32'h0000_00A5, 16'h00A5, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_WORD, 32'h0000_00F0, 32'h0,         16'h00F0, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h18, HSIZE_WORD, 32'h0000_000F, 32'h0,         16'h00FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h1C, HSIZE_WORD, 32'h0000_0030, 32'h0,         16'h00CF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h18, HSIZE_WORD, 32'h0,         32'h0,         16'h00CF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_WORD, 32'h0,         32'h0,         16'h0000, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h01, HSIZE_BYTE, 32'hFFFF_5AFF, 32'h0,         16'h5A00, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h00, HSIZE_HALF, 32'h0,         32'h0000_5A00, 16'h5A00, 16'h00FF);
        add_vec(1'b1, HTRANS_IDLE,   1'b1, 5'h00, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0,         16'h5A00, 16'h00FF);
        add_vec(1'b1, HTRANS_BUSY,   1'b1, 5'h04, HSIZE_WORD, 32'h0,         32'h0,         16'h5A00, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_HALF, 32'hFFFF_1234, 32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_BUSY,   1'b0, 5'h00, HSIZE_WORD, 32'h0,         32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h00, HSIZE_WORD, 32'h0,         32'h0000_1234, 16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_SEQ,    1'b1, 5'h0C, HSIZE_WORD, 32'h0000_FFFF, 32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h0C, HSIZE_WORD, 32'h0,         32'h0000_FFFF, 16'h1234, 16'h00FF);
        add_vec(1'b0, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_WORD, 32'h0,         32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h08, HSIZE_WORD, 32'h0,         32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h14, HSIZE_WORD, 32'h0,         32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h08, HSIZE_WORD, 32'h0000_FFFF, 32'h0,         16'h1234, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_BYTE, 32'h0000_00FF, 32'h0,         16'h12FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h1C, HSIZE_WORD, 32'h0,         32'h0,         16'h12FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h0C, HSIZE_WORD, 32'h0,         32'h0,         16'h12FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h04, HSIZE_WORD, 32'h0,         32'h0000_00FF, 16'h12FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h00, HSIZE_WORD, 32'h0,         32'h0000_12FF, 16'h12FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b1, 5'h06, HSIZE_HALF, 32'hAAAA_0000, 32'h0,         16'h12FF, 16'h00FF);
        add_vec(1'b1, HTRANS_NONSEQ, 1'b0, 5'h0C, HSIZE_WORD, 32'h0,         32'h0,         16'h12FF, 16'h00FF);

        // Reset state
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        HWDATA  = 32'h0;
        GPIO_IN = '0;
        idle();
        #1 HRESETn = 1'b0;
        #1;
        chk("rst_out",       32'(GPIO_OUT), 32'h0);
        chk("rst_oe",        32'(GPIO_OE),  32'h0);
        chk("rst_hrdata",    HRDATA,        32'h0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst_hresp",     32'(HRESP),    32'h0);
        chk("rst_irq",       32'(GPIO_IRQ), 32'h0);
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        tick();

        // Pipelined table: record i is in its address phase in iteration i
        // and in its data phase in iteration i+1.
        n = tbl.size();
        for (int i = 0; i <= n + 1; i++) begin
            HWDATA = 32'hFFFF_FFFF;
            if (i >= 1 && i - 1 < n) begin
                if (accepted(tbl[i-1]) && tbl[i-1].wr)
                    HWDATA = tbl[i-1].wdata;
                if (accepted(tbl[i-1]) && !tbl[i-1].wr) begin
                    if (rd_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL vec%0d_rd: scoreboard empty", i - 1);
                    end else begin
                        chk($sformatf("vec%0d_rd", i - 1), HRDATA, rd_q.pop_front());
                    end
                end
            end
            if (i >= 2) begin
                chk($sformatf("vec%0d_out", i - 2), 32'(GPIO_OUT), 32'(tbl[i-2].exp_out));
                chk($sformatf("vec%0d_oe", i - 2),  32'(GPIO_OE),  32'(tbl[i-2].exp_oe));
            end
            chk("hreadyout", 32'(HREADYOUT), 32'h1);
            chk("hresp",     32'(HRESP),     32'h0);
            if (i < n) begin
                drive_addr(tbl[i].hsel, tbl[i].trans, tbl[i].wr, tbl[i].addr, tbl[i].size);
                if (accepted(tbl[i]) && !tbl[i].wr)
                    rd_q.push_back(tbl[i].exp_rd);
            end else begin
                idle();
            end
            tick();
        end
        chk("rdq_empty", rd_q.size(), 32'h0);

        // Rising-edge interrupt on bit 3, DIN latency, IRQ latency, W1C
        bus_write(5'h10, 32'h0000_0008, HSIZE_WORD);
        bus_write(5'h0C, 32'h0000_0008, HSIZE_WORD);
        GPIO_IN = 16'h0008;
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 5'h08, HSIZE_WORD);
        tick();
        chk("din_after_1", HRDATA, 32'h0);
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 5'h08, HSIZE_WORD);
        tick();
        chk("din_after_2", HRDATA, 32'h0000_0008);
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 5'h14, HSIZE_WORD);
        tick();
        chk("intstat_rise", HRDATA, 32'h0000_0008);
        chk("irq_not_yet", 32'(GPIO_IRQ), 32'h0);
        idle();
        tick();
        chk("irq_set", 32'(GPIO_IRQ), 32'h1);
        bus_write(5'h14, 32'h0000_0008, HSIZE_WORD);
        chk("irq_hold", 32'(GPIO_IRQ), 32'h1);
        tick();
        chk("irq_cleared", 32'(GPIO_IRQ), 32'h0);
        GPIO_IN = 16'h0000;
        repeat (5) tick();
        bus_read(5'h14, rd);
        chk("no_fall_set", rd, 32'h0);
        chk("no_fall_irq", 32'(GPIO_IRQ), 32'h0);

        // New rising edge lands on the same edge as a W1C of the same bit
        GPIO_IN = 16'h0008;
        repeat (4) tick();
        chk("irq_rise2", 32'(GPIO_IRQ), 32'h1);
        GPIO_IN = 16'h0000;
        repeat (4) tick();
        bus_read(5'h14, rd);
        chk("intstat_latched", rd, 32'h0000_0008);
        GPIO_IN = 16'h0008;
        tick();
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 5'h14, HSIZE_WORD);
        tick();
        HWDATA = 32'h0000_0008;
        idle();
        tick();
        bus_read(5'h14, rd);
        chk("set_wins", rd, 32'h0000_0008);
        chk("set_wins_irq", 32'(GPIO_IRQ), 32'h1);

        // Reset asserted in a read data phase
        GPIO_IN = 16'h0000;
        repeat (4) tick();
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 5'h00, HSIZE_WORD);
        tick();
        chk("rd_pre_rst", HRDATA, 32'h0000_12FF);
        chk("irq_pre_rst", 32'(GPIO_IRQ), 32'h1);
        idle();
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_out",       32'(GPIO_OUT),  32'h0);
        chk("mid_rst_oe",        32'(GPIO_OE),   32'h0);
        chk("mid_rst_hrdata",    HRDATA,         32'h0);
        chk("mid_rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("mid_rst_hresp",     32'(HRESP),     32'h0);
        chk("mid_rst_irq",       32'(GPIO_IRQ),  32'h0);
        #2 HRESETn = 1'b1;
        tick();

        // Reset pulse inside a write data phase discards the write
        drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 5'h00, HSIZE_WORD);
        tick();
        HWDATA = 32'h0000_BEEF;
        idle();
        #2 HRESETn = 1'b0;
        #2 HRESETn = 1'b1;
        tick();
        chk("discard_out", 32'(GPIO_OUT), 32'h0);
        repeat (3) tick();
        bus_read(5'h14, rd);
        chk("no_spurious_edge", rd, 32'h0);
        bus_write(5'h00, 32'h0000_1234, HSIZE_WORD);
        bus_read(5'h00, rd);
        chk("post_rst_rw", rd, 32'h0000_1234);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
